// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: fetch unit is the master, memory the slave.
// IM_DATA is only meaningful in the cycle IM_ACK is high.
interface instr_fetch_if #(
    parameter int unsigned PC_W = 16
);
    logic            IM_REQ;
    logic [PC_W-1:0] IM_ADDR;
    logic            IM_ACK;
    logic [31:0]     IM_DATA;

    modport master (output IM_REQ, output IM_ADDR, input IM_ACK, input IM_DATA);
    modport slave  (input IM_REQ, input IM_ADDR, output IM_ACK, output IM_DATA);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests the word at PC, latches it into IR, holds it
// for the control unit, then advances PC on W_PC.
module instr_fetch #(
    parameter int unsigned     PC_W        = 16,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int unsigned     TIMEOUT_CYC = 255
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            W_PC,
    input  logic            TAKEN,
    input  logic [PC_W-1:0] TARGET,
    instr_fetch_if.master   im,
    output logic [PC_W-1:0] PC,
    output logic            IR_VALID,
    output logic            STALL,
    output logic [2:0]      TYPE,
    output logic [4:0]      op,
    output logic [3:0]      RD,
    output logic [3:0]      RA,
    output logic [3:0]      RB,
    output logic [15:0]     IMM,
    output logic            ILLEGAL,
    output logic            TIMEOUT,
    output logic            SEQ_ERR
);

    localparam int unsigned      CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_REQ, S_RETRY, S_HOLD} state_e;

    state_e           state, state_nxt;
    logic [31:0]      ir;
    logic [CNT_W-1:0] wait_cnt;
    logic             to_hit;

    assign to_hit = (wait_cnt == TO_LAST);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_REQ;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                if (im.IM_ACK)   state_nxt = S_HOLD;
                else if (to_hit) state_nxt = S_RETRY;
            end
            S_RETRY: state_nxt = S_REQ;
            S_HOLD:  if (W_PC) state_nxt = S_REQ;
            default: state_nxt = S_REQ;
        endcase
    end

    // Request is gated by RESET so it stays low for the whole reset pulse.
    always_comb begin
        im.IM_REQ  = RESET && (state == S_REQ);
        im.IM_ADDR = PC;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            PC       <= RESET_PC;
            ir       <= '0;
            IR_VALID <= 1'b0;
            wait_cnt <= '0;
            TIMEOUT  <= 1'b0;
            SEQ_ERR  <= 1'b0;
        end else begin
            // IR_VALID is low exactly in REQ/RETRY, so this flags out-of-sequence advances.
            if (W_PC && !IR_VALID) SEQ_ERR <= 1'b1;
            case (state)
                S_REQ: begin
                    if (im.IM_ACK) begin
                        ir       <= im.IM_DATA;
                        IR_VALID <= 1'b1;
                        wait_cnt <= '0;
                    end else if (to_hit) begin
                        TIMEOUT  <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (W_PC) begin
                        PC       <= TAKEN ? TARGET : PC + PC_W'(1);
                        IR_VALID <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign STALL   = ~IR_VALID;
    assign TYPE    = ir[31:29];
    assign op      = ir[28:24];
    assign RD      = ir[23:20];
    assign RA      = ir[19:16];
    assign RB      = ir[15:12];
    assign IMM     = ir[15:0];
    assign ILLEGAL = IR_VALID && ir[29] && (ir[30] || ir[31]);

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PC_W, default 16: program counter and address width.
REQ-002 Parameter RESET_PC, default 0: PC value loaded at reset.
REQ-003 Parameter TIMEOUT_CYC, default 255: REQ-state cycles without ACK before retry.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RESET  in  1  asynchronous, active-low reset.
REQ-006 W_PC  in  1  PC-advance pulse from control unit (asserted in its WB state).
REQ-007 TAKEN  in  1  branch/jump taken, sampled with W_PC.
REQ-008 TARGET  in  PC_W  branch/jump target, sampled with W_PC.
REQ-009 IM_REQ  out  1  instruction memory read request.
REQ-010 IM_ADDR  out  PC_W  read address (equals PC).
REQ-011 IM_ACK  in  1  memory read complete; IM_DATA valid in same cycle.
REQ-012 IM_DATA  in  32  instruction word.
REQ-013 PC  out  PC_W  current program counter.
REQ-014 IR_VALID  out  1  instruction register holds the instruction at PC.
REQ-015 STALL  out  1  equals ~IR_VALID; control unit holds in IF while high.
REQ-016 type  out  3  IR[31:29].
REQ-017 op  out  5  IR[28:24].
REQ-018 RD, RA, RB  out  4 each  IR[23:20], IR[19:16], IR[15:12].
REQ-019 IMM  out  16  IR[15:0].
REQ-020 ILLEGAL  out  1  IR_VALID and type in {011,101,111}.
REQ-021 TIMEOUT  out  1  sticky: at least one fetch retry occurred.
REQ-022 SEQ_ERR  out  1  sticky: W_PC received while IR_VALID low.

Function
REQ-023 FSM states REQ, RETRY, HOLD; registered; one transition max per cycle.
REQ-024 REQ: IM_REQ=1, IM_ADDR=PC, held stable until the cycle IM_ACK is sampled high.
REQ-025 REQ with IM_ACK=1: IR<=IM_DATA, IR_VALID<=1, wait counter<=0, next HOLD.
REQ-026 REQ with IM_ACK=0: wait counter +1; when counter reaches TIMEOUT_CYC-1 with no ACK, TIMEOUT<=1, counter<=0, next RETRY.
REQ-027 RETRY: IM_REQ=0 for exactly one cycle, IM_ACK ignored, next REQ with same PC.
REQ-028 HOLD: IM_REQ=0, IR and decoded outputs stable; IM_ACK ignored.
REQ-029 HOLD with W_PC=1: PC<=TAKEN ? TARGET : PC+1 (modulo 2^PC_W, all-ones wraps to 0), IR_VALID<=0, next REQ.
REQ-030 W_PC in REQ or RETRY: PC unchanged, no state effect, SEQ_ERR<=1.
REQ-031 W_PC and IM_ACK same cycle in REQ: ACK processed per REQ-025, W_PC per REQ-030.
REQ-032 Decoded outputs (type, op, RD, RA, RB, IMM) combinational from IR; IR unchanged while IR_VALID=0.
REQ-033 Fetch latency: IR_VALID rises the cycle after the ACK edge; minimum 1 cycle from entering REQ with zero-wait memory.

Reset
REQ-034 RESET low forces immediately: state REQ, PC=RESET_PC, IR=0, IR_VALID=0, wait counter=0, TIMEOUT=0, SEQ_ERR=0.
REQ-035 During reset IM_REQ=0; IM_REQ rises in the first cycle after RESET deasserts.
REQ-036 Reset mid-fetch or mid-HOLD abandons the transaction; any late IM_ACK before re-entering REQ is ignored.

Verification
REQ-037 Zero-wait ACK, IM_DATA=0x2A5B_C123 -> next cycle IR_VALID=1, type=001, op=01010, RD=5, RA=11, RB=12, IMM=0xC123, ILLEGAL=0.
REQ-038 HOLD, PC=0x0010, W_PC=1, TAKEN=0 -> PC=0x0011, IR_VALID=0, IM_REQ=1, IM_ADDR=0x0011; repeat TAKEN=1, TARGET=0x0400 -> PC=0x0400.
REQ-039 PC=0xFFFF, W_PC=1, TAKEN=0 -> PC=0x0000, fetch from address 0.
REQ-040 No ACK for 255 cycles -> TIMEOUT=1, IM_REQ low exactly 1 cycle, re-request same address; ACK after 3 cycles completes normally.
REQ-041 W_PC pulse during REQ with 5-wait memory -> PC unchanged, SEQ_ERR=1, fetch completes normally.
REQ-042 RESET low during REQ at PC=0x0033 -> PC=RESET_PC, IM_REQ=0, IR_VALID=0, all sticky flags cleared; IM_DATA=0xE000_0000 fetched later -> ILLEGAL=1.
